// File: rtl/int_ctrl_pkg.sv
// Shared types, defaults and the priority encoder for the interrupt controller.
package int_ctrl_pkg;

   localparam int unsigned N_SRC_DEF       = 8;
   localparam int unsigned ID_W_DEF        = $clog2(N_SRC_DEF);
   localparam int unsigned SYNC_STAGES_DEF = 2;
   localparam int unsigned PRIO_W          = 32;
   localparam int unsigned PRIO_IDX_W      = 5;

   localparam logic [PRIO_W-1:0] MASK_RST_ALL  = '1;
   localparam logic [PRIO_W-1:0] EDGE_MASK_DEF = 32'h0000_000F;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } int_state_e;

   // Lowest set index wins (bit 0 = highest priority); returns 0 for an empty vector.
   function automatic logic [PRIO_IDX_W-1:0] prio_enc(input logic [PRIO_W-1:0] req);
      logic [PRIO_IDX_W-1:0] idx;
      idx = '0;
      for (int i = PRIO_W - 1; i >= 0; i--) begin
         if (req[i]) idx = PRIO_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/int_sync_edge.sv
// Multi-flop synchronizer with rising-edge detect on the synchronized level.
module int_sync_edge
   import int_ctrl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic async_in,
   output logic sync_out,
   output logic rise_pulse
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync_out   = sync_q[SYNC_STAGES-1];
   assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: latches maskable/NMI requests and drives the CPU's INT/NMI handshake.
module int_controller
   import int_ctrl_pkg::*;
#(
   parameter int unsigned     N_SRC       = N_SRC_DEF,
   parameter int unsigned     ID_W        = $clog2(N_SRC),
   parameter logic [N_SRC-1:0] EDGE_MASK  = N_SRC'(EDGE_MASK_DEF),
   parameter int unsigned     SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [N_SRC-1:0] IRQ,
   input  logic             NMI_SRC,
   input  logic             MASK_WE,
   input  logic [N_SRC-1:0] MASK_WDATA,
   input  logic             INT_ACK,
   input  logic             EOI,
   input  logic             NMI_ACK,
   output logic             INT,
   output logic [ID_W-1:0]  INT_ID,
   output logic             NMI,
   output logic             IN_SERVICE,
   output logic [N_SRC-1:0] PENDING,
   output logic [N_SRC-1:0] MASK
);

   logic [N_SRC-1:0] irq_sync, irq_rise;
   logic             nmi_rise;

   for (genvar g = 0; g < N_SRC; g++) begin : g_irq_sync
      int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .CLK       (CLK),
         .RST_N     (RST_N),
         .async_in  (IRQ[g]),
         .sync_out  (irq_sync[g]),
         .rise_pulse(irq_rise[g])
      );
   end

   // NMI only needs the edge; its synchronized level is not used.
   logic nmi_sync_unused;
   int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .async_in  (NMI_SRC),
      .sync_out  (nmi_sync_unused),
      .rise_pulse(nmi_rise)
   );

   int_state_e       state_q, state_d;
   logic             int_q, int_d;
   logic [ID_W-1:0]  int_id_q, int_id_d;
   logic             in_service_q, in_service_d;
   logic             nmi_q, nmi_d;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] sel_c;
   logic [N_SRC-1:0] ack_clr_c;
   logic             ack_take_c;

   assign sel_c      = pend_q & ~mask_q;
   assign ack_take_c = (state_q == ST_ASSERT) && INT_ACK;
   assign ack_clr_c  = ack_take_c ? (N_SRC'(1) << int_id_q) : '0;

   // Pending: edge sources latch (set beats ack-clear), level sources mirror the line.
   always_comb begin
      pend_d = pend_q;
      for (int i = 0; i < N_SRC; i++) begin
         if (EDGE_MASK[i]) pend_d[i] = irq_rise[i] | (pend_q[i] & ~ack_clr_c[i]);
         else              pend_d[i] = irq_sync[i];
      end
   end

   always_comb begin
      mask_d = mask_q;
      if (MASK_WE) mask_d = MASK_WDATA;
   end

   always_comb begin
      nmi_d = nmi_rise | (nmi_q & ~NMI_ACK);
   end

   // Handshake FSM; INT_ID is frozen from selection until the next selection.
   always_comb begin
      state_d      = state_q;
      int_d        = int_q;
      int_id_d     = int_id_q;
      in_service_d = in_service_q;
      unique case (state_q)
         ST_IDLE: begin
            int_d = 1'b0;
            if (|sel_c) begin
               int_id_d = ID_W'(prio_enc(PRIO_W'(sel_c)));
               int_d    = 1'b1;
               state_d  = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            int_d = 1'b1;
            if (INT_ACK) begin
               int_d        = 1'b0;
               in_service_d = 1'b1;
               state_d      = ST_SERVICE;
            end
         end
         ST_SERVICE: begin
            int_d = 1'b0;
            if (EOI) begin
               in_service_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            int_d        = 1'b0;
            in_service_d = 1'b0;
            state_d      = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_IDLE;
         int_q        <= 1'b0;
         int_id_q     <= '0;
         in_service_q <= 1'b0;
         nmi_q        <= 1'b0;
         pend_q       <= '0;
         mask_q       <= N_SRC'(MASK_RST_ALL);
      end else begin
         state_q      <= state_d;
         int_q        <= int_d;
         int_id_q     <= int_id_d;
         in_service_q <= in_service_d;
         nmi_q        <= nmi_d;
         pend_q       <= pend_d;
         mask_q       <= mask_d;
      end
   end

   assign INT        = int_q;
   assign INT_ID     = int_id_q;
   assign NMI        = nmi_q;
   assign IN_SERVICE = in_service_q;
   assign PENDING    = pend_q;
   assign MASK       = mask_q;

endmodule

// File: tb/tb_int_controller.sv
// Scoreboarded bench: a delay-line reference model predicts every cycle's outputs.
module tb_int_controller;

   localparam int unsigned N  = 8;
   localparam int unsigned IW = 3;
   localparam int unsigned S  = 2;
   localparam logic [N-1:0] EDGE = 8'h0F;

   typedef struct {
      logic          i_int;
      logic [IW-1:0] i_id;
      logic          i_nmi;
      logic          i_svc;
      logic [N-1:0]  i_pend;
      logic [N-1:0]  i_mask;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  irq;
   logic          nmi_src, mask_we, int_ack, eoi, nmi_ack;
   logic [N-1:0]  mask_wdata;
   logic          int_o, nmi_o, svc_o;
   logic [IW-1:0] id_o;
   logic [N-1:0]  pend_o, mask_o;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   exp_t sb_q[$];

   // Reference model state: outputs as the CPU sees them plus input histories.
   logic          m_int, m_nmi, m_svc;
   logic [IW-1:0] m_id;
   logic [N-1:0]  m_pend, m_mask;
   logic [N-1:0]  ih[$];
   logic          nh[$];

   always #5 clk = ~clk;

   int_controller #(.N_SRC(N), .ID_W(IW), .EDGE_MASK(EDGE), .SYNC_STAGES(S)) dut (
      .CLK(clk), .RST_N(rst_n), .IRQ(irq), .NMI_SRC(nmi_src),
      .MASK_WE(mask_we), .MASK_WDATA(mask_wdata),
      .INT_ACK(int_ack), .EOI(eoi), .NMI_ACK(nmi_ack),
      .INT(int_o), .INT_ID(id_o), .NMI(nmi_o), .IN_SERVICE(svc_o),
      .PENDING(pend_o), .MASK(mask_o)
   );

   function automatic logic [IW-1:0] lowest(input logic [N-1:0] v);
      logic [IW-1:0] r;
      r = '0;
      for (int i = N - 1; i >= 0; i--) if (v[i]) r = IW'(i);
      return r;
   endfunction

   task automatic model_reset();
      m_int = 0; m_nmi = 0; m_svc = 0; m_id = '0; m_pend = '0; m_mask = '1;
      ih.delete(); nh.delete();
      for (int i = 0; i <= S; i++) begin
         ih.push_back('0);
         nh.push_back(1'b0);
      end
   endtask

   // One clock edge of the specified behaviour, using inputs held across that edge.
   task automatic model_edge();
      logic [N-1:0] rise, lvl, sel, newp;
      logic         nr, take;
      if (!rst_n) begin
         model_reset();
         return;
      end
      rise = ih[S-1] & ~ih[S];
      lvl  = ih[S-1];
      nr   = nh[S-1] & ~nh[S];
      take = m_int && int_ack;
      for (int i = 0; i < N; i++) begin
         if (EDGE[i]) newp[i] = rise[i] | (m_pend[i] & !(take && (int'(m_id) == i)));
         else         newp[i] = lvl[i];
      end
      if (m_int) begin
         if (int_ack) begin m_int = 0; m_svc = 1; end
      end else if (m_svc) begin
         if (eoi) m_svc = 0;
      end else begin
         sel = m_pend & ~m_mask;
         if (sel != '0) begin m_id = lowest(sel); m_int = 1; end
      end
      m_nmi = nr | (m_nmi & ~nmi_ack);
      if (mask_we) m_mask = mask_wdata;
      m_pend = newp;
      ih.push_front(irq);     void'(ih.pop_back());
      nh.push_front(nmi_src); void'(nh.pop_back());
   endtask

   function automatic exp_t snap();
      exp_t e;
      e.i_int = m_int; e.i_id = m_id; e.i_nmi = m_nmi; e.i_svc = m_svc;
      e.i_pend = m_pend; e.i_mask = m_mask;
      return e;
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk); #1;
         cyc++;
         model_edge();
         sb_q.push_back(snap());
      end
   endtask

   // Asynchronous reset in the middle of a cycle, checked before any further edge.
   task automatic tick_reset();
      @(posedge clk); #1;
      cyc++;
      model_edge();
      #1 rst_n = 1'b0;
      model_reset();
      sb_q.push_back(snap());
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s cycle %0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("INT",        32'(int_o),  32'(e.i_int));
            chk("INT_ID",     32'(id_o),   32'(e.i_id));
            chk("NMI",        32'(nmi_o),  32'(e.i_nmi));
            chk("IN_SERVICE", 32'(svc_o),  32'(e.i_svc));
            chk("PENDING",    32'(pend_o), 32'(e.i_pend));
            chk("MASK",       32'(mask_o), 32'(e.i_mask));
         end
      end
   end

   task automatic pulse_ack(); int_ack = 1; tick(); int_ack = 0; endtask
   task automatic pulse_eoi(); eoi = 1; tick(); eoi = 0; endtask
   task automatic wr_mask(input logic [N-1:0] v);
      mask_we = 1; mask_wdata = v; tick(); mask_we = 0;
   endtask

   initial begin : stim
      rst_n = 0; irq = '0; nmi_src = 0; mask_we = 0; mask_wdata = '0;
      int_ack = 0; eoi = 0; nmi_ack = 0;
      model_reset();
      tick(3);
      rst_n = 1;
      tick();

      // Single edge source through the full handshake
      wr_mask(8'h00);
      tick(3);
      irq[2] = 1; tick(); irq[2] = 0;
      tick(4);
      pulse_ack(); tick(2);
      pulse_eoi(); tick(2);

      // Two sources together: priority order, then re-assert after one idle cycle
      irq = 8'h22; tick(); irq = 8'h20;
      tick(4);
      pulse_ack(); tick();
      pulse_eoi(); tick(3);
      irq[5] = 0;
      pulse_ack(); tick();
      pulse_eoi(); tick(3);

      // Masked source waits in PENDING until unmasked
      wr_mask(8'hFF);
      irq[3] = 1; tick(); irq[3] = 0;
      tick(5);
      wr_mask(8'hF7); tick(3);
      pulse_ack(); pulse_eoi(); tick(2);

      // No nesting while in service; ack in idle is ignored
      wr_mask(8'h00);
      irq[4] = 1; tick(5);
      pulse_ack(); irq[4] = 0;
      irq[0] = 1; tick(); irq[0] = 0;
      tick(5);
      pulse_eoi(); tick(3);
      pulse_ack(); pulse_eoi(); tick(3);
      pulse_ack(); tick(3);

      // NMI: set, drop a second edge while high, clear
      wr_mask(8'hFF);
      nmi_src = 1; tick(2); nmi_src = 0; tick(2);
      nmi_src = 1; tick(4); nmi_src = 0;
      nmi_ack = 1; tick(); nmi_ack = 0;
      tick(6);

      // Reset mid-ASSERT with two sources pending
      nmi_src = 1; tick();
      irq = 8'h24; tick(); irq = 8'h20;
      tick(4);
      wr_mask(8'h00); tick(2);
      tick_reset();
      irq = '0; nmi_src = 0;
      tick(2);
      rst_n = 1;
      tick(2);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 3) == 0)  irq[3:0] = 4'($urandom);
         if ($urandom_range(0, 15) == 0) irq[7:4] = 4'($urandom);
         if ($urandom_range(0, 9) == 0)  nmi_src = ~nmi_src;
         int_ack    = ($urandom_range(0, 3) == 0);
         eoi        = ($urandom_range(0, 3) == 0);
         nmi_ack    = ($urandom_range(0, 7) == 0);
         mask_we    = ($urandom_range(0, 19) == 0);
         mask_wdata = 8'($urandom) & 8'($urandom);
         tick();
      end
      int_ack = 0; eoi = 0; nmi_ack = 0; mask_we = 0;
      tick(2);

      @(negedge clk); #1;
      chk("SB_DRAIN", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Interrupt controller that drives the CPU's INT and NMI inputs, sitting between peripheral interrupt lines and the multicycle CPU core.
- Synchronizes and latches N_SRC maskable requests and one non-maskable request.
- Selects the highest-priority unmasked source and presents INT plus a source ID.
- Holds each request until the CPU acknowledges entry (EPC captured) and, for maskable interrupts, signals end-of-interrupt (return from handler).

Parameters:
N_SRC, 8, number of maskable interrupt sources (2..32)
ID_W, 3, width of INT_ID; equals clog2(N_SRC)
EDGE_MASK, 8'h0F, per-source trigger mode: 1 = rising-edge latched, 0 = level
SYNC_STAGES, 2, synchronizer flops per external input (>=2)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
IRQ  in  N_SRC  asynchronous peripheral requests, bit 0 = highest priority
NMI_SRC  in  1  asynchronous non-maskable request, rising-edge triggered
MASK_WE  in  1  mask register write strobe
MASK_WDATA  in  N_SRC  new mask value, 1 = source masked
INT_ACK  in  1  one-cycle pulse from CPU: maskable interrupt taken
EOI  in  1  one-cycle pulse from CPU: handler finished
NMI_ACK  in  1  one-cycle pulse from CPU: NMI taken
INT  out  1  maskable interrupt request to CPU
INT_ID  out  ID_W  ID of the presented or in-service source
NMI  out  1  non-maskable request to CPU
IN_SERVICE  out  1  maskable handler active
PENDING  out  N_SRC  registered pending vector, for debug/status
MASK  out  N_SRC  current mask register

Behaviour:
- Reset values:
  - INT, NMI, IN_SERVICE = 0.
  - INT_ID, PENDING = 0.
  - MASK = all ones.
  - Synchronizers and edge-history flops = 0.
  - FSM = IDLE.
- Reset mid-operation discards all pending and in-service state immediately.
- Input path:
  - Each IRQ bit and NMI_SRC passes through SYNC_STAGES flops.
  - Edge detection compares the last sync stage with a one-cycle-delayed copy.
- PENDING, edge source (EDGE_MASK=1):
  - Set on a synchronized rising edge.
  - Cleared in the cycle INT_ACK is accepted with INT_ID equal to that source.
  - If set and clear happen in the same cycle, set wins.
- PENDING, level source: registered copy of the synchronized level. It is never cleared by ACK; the device must drop its line.
- Latency: IRQ sampled high at edge t gives PENDING at edge t+SYNC_STAGES and INT=1 after edge t+SYNC_STAGES+1, provided the FSM is in IDLE and the source is unmasked.
- MASK: MASK_WE loads MASK_WDATA at the clock edge. The new value affects selection from the next cycle.
- FSM states:
  - IDLE:
    - If (PENDING & ~MASK) is non-zero, latch the lowest set index into INT_ID, set INT=1 and go to ASSERT.
    - Otherwise stay in IDLE.
  - ASSERT:
    - INT stays 1 and INT_ID stays frozen, even if the source is later masked or a level source drops.
    - On INT_ACK: INT=0, IN_SERVICE=1, clear the edge-mode PENDING bit of INT_ID, go to SERVICE.
  - SERVICE:
    - INT=0, INT_ID held, no new selection.
    - On EOI: IN_SERVICE=0, go to IDLE.
    - Re-arbitration happens in the following IDLE cycle, so the minimum gap between consecutive INT assertions is one IDLE cycle.
- Ignored handshakes:
  - INT_ACK in IDLE or SERVICE.
  - EOI in IDLE or ASSERT.
  - INT_ACK and EOI together in ASSERT: INT_ACK is processed, EOI is ignored.
- No nesting: a higher-priority source arriving in ASSERT or SERVICE waits in PENDING.
- NMI path, independent of the FSM and MASK:
  - A synchronized rising edge of NMI_SRC sets NMI=1 on the next edge.
  - NMI_ACK clears NMI.
  - Edges while NMI=1 are dropped, not queued.
  - An edge coinciding with NMI_ACK re-arms NMI (set wins).
- INT and NMI may be high simultaneously. Priority between them belongs to the CPU.

Decomposition:
- Shared package int_ctrl_pkg holds:
  - FSM state enum (IDLE, ASSERT, SERVICE).
  - Default N_SRC and derived ID_W constant.
  - Reset-value constants for MASK.
- One sub-module: int_sync_edge (parameter SYNC_STAGES).
  - Ports: CLK, RST_N, async_in, sync_out, rise_pulse.
  - Instantiated N_SRC times plus once for NMI_SRC.
- Priority encoder is a function in the package, not a module.

Test Plan:
- Reset, then MASK_WE with MASK_WDATA=8'h00. Pulse IRQ[2] (edge) at edge 10 -> INT=1 and INT_ID=2 after edge 13. INT_ACK -> INT=0, IN_SERVICE=1, PENDING[2]=0. EOI -> IN_SERVICE=0.
- Unmask all, then raise IRQ[5] and IRQ[1] in the same cycle -> INT_ID=1 first. After ACK and EOI, INT reasserts with INT_ID=5 after one IDLE cycle.
- IRQ[3] edge with MASK=8'hFF -> PENDING[3]=1, INT=0. Write MASK=8'hF7 -> INT=1, INT_ID=3 one cycle after the write.
- In SERVICE for ID 4, raise IRQ[0] -> INT stays 0 until EOI, then INT_ID=0. Also, INT_ACK pulsed in IDLE -> no state change.
- NMI_SRC rising edge with MASK=8'hFF -> NMI=1 after SYNC_STAGES+1 edges. A second edge before NMI_ACK is dropped. NMI_ACK -> NMI=0 and stays 0.
- Assert RST_N=0 mid-ASSERT with PENDING=8'h24 -> INT, NMI, PENDING, IN_SERVICE go 0 asynchronously and MASK returns to 8'hFF.
